prog_loader: RTL and testbench

- UART boot loader that fills the MIPS core's instruction memory: it is the writer for the memory the core fetches from.
- Receives a length-prefixed word image on a serial line and writes each 32-bit word into the instruction RAM write port.
- Holds the core in reset while loading and releases it when loading completes.
- Sits beside pc/rom at the top level; its cpu_rst output drives the core's reset.

---
 rtl/prog_loader.sv | 192 +++++++++++++++++++
 tb/tb_prog_loader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// UART boot loader: receives a length-prefixed big-endian word image and writes it into
// instruction memory, holding the core in reset until done. Optional: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [2:0] {
    L_IDLE, L_LEN_LO, L_DATA, L_WRITE, L_DONE, L_ERR
`ifdef PROG_LOADER_CHECKSUM_EN
    , L_CHK
`endif
  } ld_st_t;

  // ---------------- UART receiver ----------------
  logic [2:0]    sync_q;     // [1] is the synchronized line, [2] its previous value
  rx_st_t        rx_st_q, rx_st_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          byte_valid, frame_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 3'b111;
      rx_st_q <= R_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], rxd};
      rx_st_q <= rx_st_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    tmr_d      = tmr_q + 1'b1;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        tmr_d = '0;
        if (sync_q[2] && !sync_q[1]) rx_st_d = R_START;
      end
      R_START:
        if (tmr_q == HALF_M1) begin
          tmr_d   = '0;
          bit_d   = '0;
          rx_st_d = sync_q[1] ? R_IDLE : R_DATA;  // high at mid-start: glitch
        end
      R_DATA:
        if (tmr_q == FULL_M1) begin
          tmr_d = '0;
          sh_d  = {sync_q[1], sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) rx_st_d = R_STOP;
        end
      R_STOP:
        if (tmr_q == FULL_M1) begin
          rx_st_d    = R_IDLE;
          byte_valid = sync_q[1];
          frame_err  = !sync_q[1];
        end
      default: rx_st_d = R_IDLE;
    endcase
  end

  // ---------------- Loader FSM ----------------
  ld_st_t          st_q, st_d;
  logic [15:0]     len_q, len_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic [1:0]      bc_q, bc_d;
  logic [23:0]     wsh_q, wsh_d;
  logic [31:0]     wd_q, wd_d, addr_q, addr_d;
  logic [15:0]     n_rx, idx_nx;
  ld_st_t          fin_st;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]      cs_q, cs_d;
  assign fin_st = L_CHK;
`else
  assign fin_st = L_DONE;
`endif

  assign n_rx   = {len_q[15:8], sh_q};
  assign idx_nx = 16'(idx_q) + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= L_IDLE;
      len_q  <= '0;
      idx_q  <= '0;
      bc_q   <= '0;
      wsh_q  <= '0;
      wd_q   <= '0;
      addr_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      cs_q   <= '0;
`endif
    end else begin
      st_q   <= st_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      bc_q   <= bc_d;
      wsh_q  <= wsh_d;
      wd_q   <= wd_d;
      addr_q <= addr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      cs_q   <= cs_d;
`endif
    end
  end

  always_comb begin
    st_d   = st_q;
    len_d  = len_q;
    idx_d  = idx_q;
    bc_d   = bc_q;
    wsh_d  = wsh_q;
    wd_d   = wd_q;
    addr_d = addr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    cs_d   = cs_q;
`endif
    case (st_q)
      L_IDLE:
        if (byte_valid) begin
          len_d[15:8] = sh_q;
          st_d        = L_LEN_LO;
        end
      L_LEN_LO:
        if (byte_valid) begin
          len_d = n_rx;
          if (n_rx == 16'd0)                         st_d = fin_st;
          else if ({1'b0, n_rx} > (17'd1 << ADDR_W)) st_d = L_ERR;
          else                                       st_d = L_DATA;
        end
      L_DATA:
        if (byte_valid) begin
          wsh_d = {wsh_q[15:0], sh_q};
          bc_d  = bc_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          cs_d  = cs_q ^ sh_q;
`endif
          if (bc_q == 2'd3) begin
            wd_d   = {wsh_q, sh_q};
            addr_d = {{(30-ADDR_W){1'b0}}, idx_q[ADDR_W-1:0], 2'b00};
            st_d   = L_WRITE;
          end
        end
      L_WRITE: begin
        idx_d = idx_q + 1'b1;
        st_d  = (idx_nx == len_q) ? fin_st : L_DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      L_CHK:
        if (byte_valid) st_d = (sh_q == cs_q) ? L_DONE : L_ERR;
`endif
      default: st_d = st_q;
    endcase
    // Framing errors abort any byte-receiving state; terminal states ignore the line.
    if (frame_err && st_q != L_WRITE && st_q != L_DONE && st_q != L_ERR) st_d = L_ERR;
  end

  assign imem_we   = (st_q == L_WRITE);
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;
  assign done      = (st_q == L_DONE);
  assign err       = (st_q == L_ERR);
  assign cpu_rst   = done;
  assign busy      = !(st_q == L_IDLE || done || err);
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed UART images, expected writes queued, monitor checks.
module tb_prog_loader;
  logic        clk = 1'b0, rst = 1'b0, rxd = 1'b1;
  logic        imem_we, cpu_rst, busy, done, err;
  logic [31:0] imem_addr, imem_wd;
  int          checks = 0, errors = 0;

  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  typedef logic [7:0] bq_t[$];
  wr_t exp_q[$];

  always #5 clk = ~clk;

  prog_loader #(.CLKS_PER_BIT(4), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wd(imem_wd), .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none", imem_addr, imem_wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", imem_addr, e.a);
        chk("write_data", imem_wd, e.d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic bad_stop);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (4) @(negedge clk);
    end
    rxd = ~bad_stop;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_list(input bq_t l);
    foreach (l[i]) send_byte(l[i], 1'b0);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Holds reset long enough to look at every output, then releases it.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wd", imem_wd, 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL end_timeout: got done=%0b err=%0b expected one of them set", done, err);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic expect_end(input string tag, input logic d, input logic e);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(d));
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    do_reset();

    // Two-word image
    push(32'h0, 32'h24080005);
    push(32'h4, 32'h00000008);
    send_byte(8'h00, 1'b0);
    chk("busy_after_len_hi", 32'(busy), 1);
    chk("cpu_held_loading", 32'(cpu_rst), 0);
    send_list('{8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08});
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h21, 1'b0);
`endif
    wait_end();
    expect_end("two_words", 1'b1, 1'b0);

    // Empty image
    do_reset();
    send_list('{8'h00, 8'h00});
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    wait_end();
    expect_end("empty", 1'b1, 1'b0);

    // 17 words exceeds 16-word memory
    do_reset();
    send_list('{8'h00, 8'h11});
    wait_end();
    expect_end("too_long", 1'b0, 1'b1);

    // Framing error in data, then further traffic must not write
    do_reset();
    send_list('{8'h00, 8'h01});
    send_byte(8'h55, 1'b1);
    wait_end();
    expect_end("frame_err", 1'b0, 1'b1);
    send_list('{8'h11, 8'h22, 8'h33, 8'h44});
    repeat (10) @(negedge clk);
    expect_end("after_err", 1'b0, 1'b1);

    // One-cycle glitch followed by a valid image
    do_reset();
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_busy", 32'(busy), 0);
    push(32'h0, 32'hDEADBEEF);
    send_list('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h22, 1'b0);
`endif
    wait_end();
    expect_end("glitch", 1'b1, 1'b0);

    // Reset mid-load, then a full reload from address 0
    do_reset();
    send_list('{8'h00, 8'h01, 8'h11, 8'h22});
    do_reset();
    push(32'h0, 32'h11223344);
    send_list('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44});
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(8'h44, 1'b0);
`endif
    wait_end();
    expect_end("reload", 1'b1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Bad checksum: word still written, core stays held
    do_reset();
    push(32'h0, 32'h11223344);
    send_list('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45});
    wait_end();
    expect_end("bad_csum", 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
